// File: rtl/br_pool_pkg.sv
// Shared types and lane compare for the 2x2 max-pool stage; BR_POOL_UNSIGNED_EN selects unsigned lane compares.
// Latency: none (types, constants and a combinational function only).
// Backpressure: not applicable.
package br_pool_pkg;

  localparam int BUSWIDTH_DEF = 512;
  localparam int DATAW_DEF    = 8;
  localparam int LANES        = BUSWIDTH_DEF / DATAW_DEF;
  localparam int HALF         = LANES / 2;

  // Widest lane the compare function accepts; narrower lanes are zero-extended.
  localparam int LANE_MAXW = 64;

`ifdef BR_POOL_UNSIGNED_EN
  localparam bit SIGNED_CMP = 1'b0;
`else
  localparam bit SIGNED_CMP = 1'b1;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ROW_A,
    ROW_B,
    FLUSH,
    DONE
  } poolState_e;

  // a >= b for w-bit lanes held zero-extended; for signed lanes the sign bit is
  // flipped so that a plain unsigned compare orders two's-complement values.
  function automatic logic laneGe(input logic [LANE_MAXW-1:0] a,
                                  input logic [LANE_MAXW-1:0] b,
                                  input int w);
    logic [LANE_MAXW-1:0] signFlip;
    signFlip = '0;
    for (int i = 0; i < LANE_MAXW; i++) begin
      if (SIGNED_CMP && (i == w - 1)) signFlip[i] = 1'b1;
    end
    return ((a ^ signFlip) >= (b ^ signFlip));
  endfunction

endpackage

// File: rtl/br_pool_lane_max.sv
// Lane-wise max of two vectors of HALFN lanes, each DATAW bits wide.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module br_pool_lane_max
  import br_pool_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int HALFN = 2
) (
  input  logic [HALFN*DATAW-1:0] aVec,
  input  logic [HALFN*DATAW-1:0] bVec,
  output logic [HALFN*DATAW-1:0] maxVec
);

  logic [LANE_MAXW-1:0] aLane;
  logic [LANE_MAXW-1:0] bLane;

  // Pick the larger element of each lane pair.
  always_comb begin
    maxVec = '0;
    aLane  = '0;
    bLane  = '0;
    for (int k = 0; k < HALFN; k++) begin
      aLane = '0;
      bLane = '0;
      aLane[DATAW-1:0] = aVec[k*DATAW +: DATAW];
      bLane[DATAW-1:0] = bVec[k*DATAW +: DATAW];
      maxVec[k*DATAW +: DATAW] = laneGe(aLane, bLane, DATAW) ? aVec[k*DATAW +: DATAW]
                                                              : bVec[k*DATAW +: DATAW];
    end
  end

endmodule

// File: rtl/br_maxpool.sv
// 2x2 max-pool of row lines, two pooled rows packed per output line; bypass passes rows through. Macro BR_POOL_UNSIGNED_EN: unsigned compares.
// Latency: output line 1 cycle after the beat completing it (flush adds 1); Done 1 cycle after the last output.
// Backpressure: none; one input beat per cycle accepted, output is a valid-only pulse.
module br_maxpool
  import br_pool_pkg::*;
#(
  parameter int BUSWIDTH = BUSWIDTH_DEF,
  parameter int DATAW    = DATAW_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                Pool_Start_i,
  input  logic [8:0]          Height_i,
  input  logic                PoolEn_i,
  input  logic                Data_en_i,
  input  logic [BUSWIDTH-1:0] Data_i,
  output logic                Result_en_o,
  output logic [BUSWIDTH-1:0] Result_o,
  output logic                Pool_Done_o
);

  localparam int LaneCnt = BUSWIDTH / DATAW;
  localparam int HalfCnt = LaneCnt / 2;
  localparam int HalfW   = HalfCnt * DATAW;

  poolState_e state, stateNxt;
  logic [8:0]          heightReg, heightNxt;
  logic                poolEn, poolEnNxt;
  logic [8:0]          rowCnt, rowCntNxt;
  logic                halfSel, halfSelNxt;
  logic [HalfW-1:0]    hbuf, hbufNxt;
  logic [HalfW-1:0]    packReg, packNxt;
  logic [BUSWIDTH-1:0] resNxt;
  logic                resEnNxt;
  logic                doneNxt;

  logic [HalfW-1:0] evenLanes, oddLanes, hCur, vMax, poolRow;
  logic             poolVld;

  // Split the incoming line into even and odd lanes for the horizontal pass.
  always_comb begin
    evenLanes = '0;
    oddLanes  = '0;
    for (int k = 0; k < HalfCnt; k++) begin
      evenLanes[k*DATAW +: DATAW] = Data_i[(2*k)*DATAW +: DATAW];
      oddLanes[k*DATAW +: DATAW]  = Data_i[(2*k+1)*DATAW +: DATAW];
    end
  end

  br_pool_lane_max #(.DATAW(DATAW), .HALFN(HalfCnt)) uHoriz (
    .aVec  (evenLanes),
    .bVec  (oddLanes),
    .maxVec(hCur)
  );

  br_pool_lane_max #(.DATAW(DATAW), .HALFN(HalfCnt)) uVert (
    .aVec  (hbuf),
    .bVec  (hCur),
    .maxVec(vMax)
  );

  // Sequencing, row pairing and line packing.
  always_comb begin
    stateNxt   = state;
    heightNxt  = heightReg;
    poolEnNxt  = poolEn;
    rowCntNxt  = rowCnt;
    halfSelNxt = halfSel;
    hbufNxt    = hbuf;
    packNxt    = packReg;
    resNxt     = Result_o;
    resEnNxt   = 1'b0;
    doneNxt    = 1'b0;
    poolRow    = '0;
    poolVld    = 1'b0;

    case (state)
      IDLE: begin
        if (Pool_Start_i) begin
          heightNxt  = Height_i;
          poolEnNxt  = PoolEn_i;
          rowCntNxt  = '0;
          halfSelNxt = 1'b0;
          packNxt    = '0;
          stateNxt   = (Height_i == 9'd0) ? DONE : ROW_A;
        end
      end
      ROW_A: begin
        if (Data_en_i) begin
          rowCntNxt = rowCnt + 9'd1;
          if (!poolEn) begin
            resNxt   = Data_i;
            resEnNxt = 1'b1;
            if (rowCntNxt == heightReg) stateNxt = DONE;
          end else begin
            hbufNxt = hCur;
            if (rowCntNxt == heightReg) begin
              // Odd height: the last row is pooled horizontally only.
              poolRow = hCur;
              poolVld = 1'b1;
            end else begin
              stateNxt = ROW_B;
            end
          end
        end
      end
      ROW_B: begin
        if (Data_en_i) begin
          rowCntNxt = rowCnt + 9'd1;
          poolRow   = vMax;
          poolVld   = 1'b1;
        end
      end
      FLUSH: begin
        if (halfSel) begin
          resNxt     = {{HalfW{1'b0}}, packReg};
          resEnNxt   = 1'b1;
          packNxt    = '0;
          halfSelNxt = 1'b0;
        end
        stateNxt = DONE;
      end
      DONE: begin
        doneNxt  = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase

    // A finished pooled row fills the low half, or completes and emits the line.
    if (poolVld) begin
      if (!halfSel) begin
        packNxt    = poolRow;
        halfSelNxt = 1'b1;
      end else begin
        resNxt     = {poolRow, packReg};
        resEnNxt   = 1'b1;
        packNxt    = '0;
        halfSelNxt = 1'b0;
      end
      if (rowCntNxt == heightReg) stateNxt = halfSelNxt ? FLUSH : DONE;
      else                        stateNxt = ROW_A;
    end
  end

  // State and output registers; reset aborts any tile in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      heightReg   <= '0;
      poolEn      <= 1'b0;
      rowCnt      <= '0;
      halfSel     <= 1'b0;
      hbuf        <= '0;
      packReg     <= '0;
      Result_o    <= '0;
      Result_en_o <= 1'b0;
      Pool_Done_o <= 1'b0;
    end else begin
      state       <= stateNxt;
      heightReg   <= heightNxt;
      poolEn      <= poolEnNxt;
      rowCnt      <= rowCntNxt;
      halfSel     <= halfSelNxt;
      hbuf        <= hbufNxt;
      packReg     <= packNxt;
      Result_o    <= resNxt;
      Result_en_o <= resEnNxt;
      Pool_Done_o <= doneNxt;
    end
  end

endmodule

// File: tb/tb_br_maxpool.sv
// Scoreboard bench for br_maxpool at BUSWIDTH=32, DATAW=8; expectations follow BR_POOL_UNSIGNED_EN.
// Latency: expected cycle of every output pulse is checked.
// Backpressure: none on the DUT; the monitor pops on every Result_en_o/Pool_Done_o.
module tb_br_maxpool;

  logic        clk;
  logic        rstn;
  logic        Pool_Start_i;
  logic [8:0]  Height_i;
  logic        PoolEn_i;
  logic        Data_en_i;
  logic [31:0] Data_i;
  logic        Result_en_o;
  logic [31:0] Result_o;
  logic        Pool_Done_o;

  typedef struct {
    bit          isDone;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t monE;
  int   cyc;
  int   nChecks;
  int   nErr;

  br_maxpool #(.BUSWIDTH(32), .DATAW(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .Pool_Start_i(Pool_Start_i),
    .Height_i    (Height_i),
    .PoolEn_i    (PoolEn_i),
    .Data_en_i   (Data_en_i),
    .Data_i      (Data_i),
    .Result_en_o (Result_en_o),
    .Result_o    (Result_o),
    .Pool_Done_o (Pool_Done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic flagErr(input string name, input logic [31:0] act);
    nChecks++;
    nErr++;
    $display("FAIL %s: got 0x%0h expected no event", name, act);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && Result_en_o) begin
      if (sb.size() == 0) flagErr("unexpected_result", Result_o);
      else begin
        monE = sb.pop_front();
        if (monE.isDone) flagErr("result_instead_of_done", Result_o);
        else begin
          check("result_data", Result_o, monE.dat);
          check("result_cycle", cyc, monE.cyc);
        end
      end
    end
    if (rstn && Pool_Done_o) begin
      if (sb.size() == 0) flagErr("unexpected_done", 32'(cyc));
      else begin
        monE = sb.pop_front();
        if (!monE.isDone) flagErr("done_instead_of_result", monE.dat);
        else check("done_cycle", cyc, monE.cyc);
      end
    end
  end

  task automatic expRes(input logic [31:0] d, input int c);
    exp_t e;
    e.isDone = 1'b0; e.dat = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic expDone(input int c);
    exp_t e;
    e.isDone = 1'b1; e.dat = '0; e.cyc = c;
    sb.push_back(e);
  endtask

  // All drivers are entered on a falling edge and leave on the next one.
  task automatic drvStart(input logic [8:0] h, input logic en);
    Pool_Start_i = 1'b1; Height_i = h; PoolEn_i = en;
    @(negedge clk);
    Pool_Start_i = 1'b0;
  endtask

  task automatic drvBeat(input logic [31:0] d);
    Data_en_i = 1'b1; Data_i = d;
    @(negedge clk);
    Data_en_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      flagErr("timeout_pending_events", 32'(sb.size()));
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  logic [31:0] bypassRows [3];
  int c;

  initial begin
    cyc = 0; nChecks = 0; nErr = 0;
    rstn = 1'b0; Pool_Start_i = 1'b0; Height_i = '0; PoolEn_i = 1'b0;
    Data_en_i = 1'b0; Data_i = '0;
    repeat (3) @(negedge clk);
    check("reset_result_en", {31'b0, Result_en_o}, 32'h0);
    check("reset_result", Result_o, 32'h0);
    check("reset_done", {31'b0, Pool_Done_o}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Beat while idle is ignored.
    drvBeat(32'h11223344);
    drain();

    // H=2 pooled: completes via flush.
    drvStart(9'd2, 1'b1);
    drvBeat(32'h04030201);
    c = cyc + 1;
    expRes(32'h00000806, c + 1);
    expDone(c + 2);
    drvBeat(32'h01080506);
    drain();

    // H=4 pooled, with a stray Start mid-tile that must be ignored.
    drvStart(9'd4, 1'b1);
    drvBeat(32'h04030201);
    drvStart(9'd0, 1'b1);
    drvBeat(32'h01080506);
    drvBeat(32'h10203040);
    c = cyc + 1;
    expRes(32'h20400806, c);
    expDone(c + 1);
    drvBeat(32'h0A0B0C0D);
    drvBeat(32'h7F7F7F7F);
    drain();

    // H=3 pooled: last row horizontal only.
    drvStart(9'd3, 1'b1);
    drvBeat(32'h04030201);
    drvBeat(32'h01080506);
    c = cyc + 1;
    expRes(32'h7F110806, c);
    expDone(c + 1);
    drvBeat(32'h7F000011);
    drain();

    // H=1: sign of the compare decides the lane.
    drvStart(9'd1, 1'b1);
    c = cyc + 1;
`ifdef BR_POOL_UNSIGNED_EN
    expRes(32'h000000FF, c + 1);
`else
    expRes(32'h00000001, c + 1);
`endif
    expDone(c + 2);
    drvBeat(32'h0000FF01);
    drain();

    // Bypass, H=3.
    bypassRows[0] = 32'hDEADBEEF;
    bypassRows[1] = 32'h80FF017F;
    bypassRows[2] = 32'h12345678;
    drvStart(9'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      c = cyc + 1;
      expRes(bypassRows[i], c);
      if (i == 2) expDone(c + 1);
      drvBeat(bypassRows[i]);
    end
    drain();

    // H=0 pooled: Done only.
    c = cyc + 1;
    expDone(c + 1);
    drvStart(9'd0, 1'b1);
    drain();

    // Reset mid-tile.
    drvStart(9'd4, 1'b1);
    drvBeat(32'h55667788);
    rstn = 1'b0;
    #1;
    check("midreset_result_en", {31'b0, Result_en_o}, 32'h0);
    check("midreset_result", Result_o, 32'h0);
    check("midreset_done", {31'b0, Pool_Done_o}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Fresh H=2 tile after the abort, with negative lanes.
    drvStart(9'd2, 1'b1);
    drvBeat(32'h80FF7F01);
    c = cyc + 1;
`ifdef BR_POOL_UNSIGNED_EN
    expRes(32'h0000FF7F, c + 1);
`else
    expRes(32'h0000027F, c + 1);
`endif
    expDone(c + 2);
    drvBeat(32'h01020304);
    drain();

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/br_maxpool.md
Name: br_maxpool

Overview:
- Optional 2x2 max-pool stage directly downstream of the bias/ReLU datapath.
- Consumes the per-row result-line beats that would otherwise go straight to the write-back master.
- Pools horizontally within a line and vertically across row pairs, then packs two pooled rows into one output line for the write master.
- Sequenced by the same Start/Done style pulses the layer controller already issues.

Parameters:
- BUSWIDTH, 512, width of input/output lines in bits.
- DATAW, 8, width of one lane element; BUSWIDTH must be a multiple of 2*DATAW.
- LANES, BUSWIDTH/DATAW, derived; lanes per line. Lane i occupies bits [i*DATAW +: DATAW].

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- Pool_Start_i  in  1  one-cycle start pulse; latches Height_i and PoolEn_i.
- Height_i  in  9  rows in this tile (0..511).
- PoolEn_i  in  1  1 = pool, 0 = bypass.
- Data_en_i  in  1  input beat valid (one row line per beat, no backpressure).
- Data_i  in  BUSWIDTH  input row line.
- Result_en_o  out  1  output beat valid, one-cycle pulse.
- Result_o  out  BUSWIDTH  output line.
- Pool_Done_o  out  1  one-cycle pulse when the tile has completed.

Behaviour:
- Reset values: Result_en_o=0, Result_o=0, Pool_Done_o=0, state=IDLE, all counters and buffers 0.
- Reset is asynchronous; asserting it mid-tile aborts the tile immediately, with no partial output and no Done.
- States: IDLE, ROW_A (awaiting even row), ROW_B (awaiting odd row), FLUSH, DONE.
- IDLE:
  - Data_en_i is ignored.
  - On Pool_Start_i, latch H=Height_i and mode, clear row_cnt and half_sel.
  - If H==0, go to DONE; else go to ROW_A.
- Pool_Start_i outside IDLE is ignored.
- Horizontal max: for row r, h[k] = max(lane 2k, lane 2k+1) for k in 0..LANES/2-1. Comparison is signed (see Optional Feature).
- ROW_A, on a beat:
  - Store h() of the row in hbuf and increment row_cnt.
  - If row_cnt reaches H (odd H, last row), the pooled row is hbuf itself; go to FLUSH.
  - Otherwise go to ROW_B.
- ROW_B, on a beat: pooled p[k] = max(hbuf[k], h[k]); increment row_cnt.
- Packing:
  - Pooled row with half_sel=0 goes to pack-register lanes 0..LANES/2-1, and half_sel toggles.
  - Pooled row with half_sel=1 goes to lanes LANES/2..LANES-1. Result_o is then the full pack register, Result_en_o pulses, and the pack register clears.
- Latency: Result_en_o asserts in the cycle after the beat that completes the output line.
- End of tile: when row_cnt reaches H, go to FLUSH.
- FLUSH:
  - If half_sel=1, emit the pack register with the upper half zero-filled (Result_en_o one cycle).
  - Go to DONE.
- DONE: Pool_Done_o pulses for one cycle, one cycle after the final Result_en_o (or after Start when H==0); then return to IDLE.
- Output counts: pooled rows P=ceil(H/2); output lines = ceil(P/2).
- Beats arriving after row_cnt reaches H are ignored.
- Bypass (PoolEn latched 0):
  - Result_o = Data_i, registered, with 1-cycle latency per beat.
  - Done follows the H-th beat's output by one cycle.
- Result_o holds its last value between pulses.

Optional Feature:
- Macro BR_POOL_UNSIGNED_EN.
- Defined: lane comparisons are unsigned, for use when the ReLU is always enabled upstream.
- Not defined (default): comparisons are two's-complement signed.

Decomposition:
- Package br_pool_pkg: state enum, the derived LANES and HALF=LANES/2 constants, and the lane-compare function selected by the macro.
- One sub-module, br_pool_lane_max: a combinational pairwise max across HALF lanes (inputs are two HALF*DATAW vectors), instantiated for both the horizontal and vertical passes.

Test Plan:
All tests use BUSWIDTH=32, DATAW=8, signed compare unless stated; line values are written lane3..lane0.
- H=2, Data_i 0x04030201 then 0x01080506 -> one Result_en_o, Result_o=0x00000806, then Pool_Done_o next cycle.
- H=4, rows 0x04030201, 0x01080506, 0x10203040, 0x0A0B0C0D -> single output 0x20400806; Done one cycle later.
- H=3, rows 0x04030201, 0x01080506, 0x7F000011 -> single output 0x7F110806 (third row passes horizontal max only).
- H=1, Data_i 0x0000FF01, signed -> output 0x00000001. Same stimulus with BR_POOL_UNSIGNED_EN -> 0x000000FF.
- PoolEn_i=0, H=3, three arbitrary beats -> three outputs equal to the inputs, each delayed 1 cycle, then Done. H=0 with pooling -> no Result_en_o, Done one cycle after Start.
- Reset mid-op: after the first beat of an H=4 tile, assert rstn=0 -> all outputs 0 immediately. A new Start with H=2 then produces a correct result, with no residue from the aborted tile in the pack register.
